// File: rtl/dummy_decoder_if.sv
// AxisIf: minimal AXI-Stream bundle (tvalid/tready/tdata/tlast) shared by
// the control, data and status channels of the dummy decoder.
interface AxisIf #(
  parameter int WIDTH = 32
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/dummy_decoder.sv
// dummy_decoder: per-frame passthrough "decoder".
// A control word gives the expected frame length and a tag; data beats are
// forwarded through a one-entry output register with a generated tlast, and a
// status word reports beats seen plus early/missing tlast flags.
// Optional feature: define DUMMY_DECODER_DRAIN_EN to discard the surplus beats
// of an over-long frame (up to its tlast) instead of leaving them for the next
// frame.
module dummy_decoder #(
  parameter int CTRL_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic  clk,
  input  logic  resetn,
  AxisIf.slave  s_axis_control,
  AxisIf.slave  s_axis_din,
  AxisIf.master m_axis_status,
  AxisIf.master m_axis_dout
);

  if (CTRL_WIDTH < 32) begin : g_bad_ctrl_width
    $error("dummy_decoder: CTRL_WIDTH must be >= 32");
  end

  if (($bits(s_axis_din.tdata) != DATA_WIDTH) ||
      ($bits(m_axis_dout.tdata) != DATA_WIDTH)) begin : g_bad_data_width
    $error("dummy_decoder: din/dout tdata widths must equal DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef DUMMY_DECODER_DRAIN_EN
    DRAIN  = 2'd2,
`endif
    STATUS = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           length_q;
  logic [7:0]            tag_q;
  logic [15:0]           count_q;
  logic                  early_q;
  logic                  missing_q;
  logic                  dout_valid_q;
  logic                  dout_last_q;
  logic [DATA_WIDTH-1:0] dout_data_q;

  logic        ctrl_ready;
  logic        din_ready;
  logic        status_valid;
  logic        ctrl_hs;
  logic        din_hs;
  logic [15:0] count_inc;
  logic        at_length;

  assign ctrl_hs   = s_axis_control.tvalid && ctrl_ready;
  assign din_hs    = s_axis_din.tvalid && din_ready;
  assign count_inc = count_q + 16'd1;
  assign at_length = (count_inc == length_q);

  // State register; reset always returns to IDLE so a partial frame is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state handshake enables.
  always_comb begin
    state_d      = state_q;
    ctrl_ready   = 1'b0;
    din_ready    = 1'b0;
    status_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_hs) begin
          state_d = (s_axis_control.tdata[15:0] == 16'd0) ? STATUS : DATA;
        end
      end
      DATA: begin
        din_ready = !dout_valid_q || m_axis_dout.tready;
        if (din_hs) begin
          if (s_axis_din.tlast) begin
            state_d = STATUS;
          end else if (at_length) begin
`ifdef DUMMY_DECODER_DRAIN_EN
            state_d = DRAIN;
`else
            state_d = STATUS;
`endif
          end
        end
      end
`ifdef DUMMY_DECODER_DRAIN_EN
      DRAIN: begin
        din_ready = 1'b1;
        if (din_hs && s_axis_din.tlast) begin
          state_d = STATUS;
        end
      end
`endif
      STATUS: begin
        status_valid = 1'b1;
        if (m_axis_status.tready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame bookkeeping: latch length/tag at control accept, count and flag beats.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      length_q  <= '0;
      tag_q     <= '0;
      count_q   <= '0;
      early_q   <= 1'b0;
      missing_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (ctrl_hs) begin
        length_q  <= s_axis_control.tdata[15:0];
        tag_q     <= s_axis_control.tdata[23:16];
        count_q   <= '0;
        early_q   <= (s_axis_control.tdata[15:0] == 16'd0);
        missing_q <= 1'b0;
      end
    end else if ((state_q == DATA) && din_hs) begin
      count_q <= count_inc;
      if (s_axis_din.tlast && !at_length) begin
        early_q <= 1'b1;
      end
      if (!s_axis_din.tlast && at_length) begin
        missing_q <= 1'b1;
      end
    end
  end

  // One-entry output register; a new beat may land in the same cycle the old one leaves.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_data_q  <= '0;
    end else if ((state_q == DATA) && din_hs) begin
      dout_valid_q <= 1'b1;
      dout_last_q  <= s_axis_din.tlast || at_length;
      dout_data_q  <= s_axis_din.tdata;
    end else if (m_axis_dout.tready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign s_axis_control.tready = ctrl_ready;
  assign s_axis_din.tready     = din_ready;

  assign m_axis_dout.tvalid = dout_valid_q;
  assign m_axis_dout.tlast  = dout_last_q;
  assign m_axis_dout.tdata  = dout_data_q;

  assign m_axis_status.tvalid = status_valid;
  assign m_axis_status.tlast  = 1'b1;
  assign m_axis_status.tdata  = status_valid ?
      {{(CTRL_WIDTH-26){1'b0}}, missing_q, early_q, tag_q, count_q} : '0;

endmodule
